// File: rtl/display_arbiter.sv
// display_arbiter: shares one 8-digit seven-segment datapath between several
// BCD sources. Round-robin ownership with a minimum hold measured in tick_in
// strobes. All outputs are registered and change together on the grant edge.
module display_arbiter #(
    parameter int              NUM_REQ    = 3,
    parameter int              DATA_W     = 32,
    parameter int              MIN_HOLD   = 4,
    parameter logic [DATA_W-1:0] BLANK_WORD = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_in,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         time_data,
    output logic                      valid,
    output logic                      switch
);

    // MIN_HOLD = 0 would give a zero-width counter; keep at least one bit.
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        SHARE = 2'd2
    } state_t;

    state_t              state_r;
    logic [HW-1:0]       hold_cnt_r;
    logic [IW-1:0]       last_idx_r;

    logic [NUM_REQ-1:0]  mask_s;
    logic                win_found_s;
    logic [IW-1:0]       win_idx_s;
    logic [NUM_REQ-1:0]  win_onehot_s;
    logic                owner_req_s;

    state_t              nxt_state_s;
    logic [NUM_REQ-1:0]  nxt_grant_s;
    logic [IW-1:0]       nxt_last_s;
    logic [HW-1:0]       nxt_hold_s;
    logic [DATA_W-1:0]   data_sel_s;
    logic [DATA_W-1:0]   nxt_data_s;

    // Round-robin search starting after last_idx_r; the current owner is
    // masked out so a rotation always lands on a different source.
    always_comb begin
        mask_s      = req & ~grant;
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                win_idx_s   = (!win_found_s && mask_s[i] &&
                               (((int'(last_idx_r) + k) % NUM_REQ) == i))
                              ? IW'(i) : win_idx_s;
                win_found_s = win_found_s | (mask_s[i] &&
                              (((int'(last_idx_r) + k) % NUM_REQ) == i));
            end
        end
        win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        owner_req_s  = |(req & grant);
    end

    // Next ownership decision: owner drop beats hold counting, and
    // competitors are only honoured once the hold time has elapsed.
    always_comb begin
        nxt_state_s = state_r;
        nxt_grant_s = grant;
        nxt_last_s  = last_idx_r;
        nxt_hold_s  = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    nxt_state_s = OWN;
                    nxt_grant_s = win_onehot_s;
                    nxt_last_s  = win_idx_s;
                    nxt_hold_s  = {HW{1'b0}};
                end else begin
                    nxt_state_s = IDLE;
                    nxt_grant_s = {NUM_REQ{1'b0}};
                end
            end
            OWN, SHARE: begin
                if (!owner_req_s) begin
                    if (win_found_s) begin
                        nxt_state_s = OWN;
                        nxt_grant_s = win_onehot_s;
                        nxt_last_s  = win_idx_s;
                        nxt_hold_s  = {HW{1'b0}};
                    end else begin
                        nxt_state_s = IDLE;
                        nxt_grant_s = {NUM_REQ{1'b0}};
                        nxt_hold_s  = {HW{1'b0}};
                    end
                end else if (state_r == OWN) begin
                    if (hold_cnt_r >= HOLD_MAX) begin
                        nxt_state_s = SHARE;
                    end else if (tick_in) begin
                        nxt_hold_s  = hold_cnt_r + HW'(1);
                        nxt_state_s = ((hold_cnt_r + HW'(1)) >= HOLD_MAX) ? SHARE : OWN;
                    end else begin
                        nxt_state_s = OWN;
                    end
                end else begin
                    if (win_found_s) begin
                        nxt_state_s = OWN;
                        nxt_grant_s = win_onehot_s;
                        nxt_last_s  = win_idx_s;
                        nxt_hold_s  = {HW{1'b0}};
                    end else begin
                        nxt_state_s = SHARE;
                    end
                end
            end
            default: begin
                nxt_state_s = IDLE;
                nxt_grant_s = {NUM_REQ{1'b0}};
                nxt_last_s  = LAST_RST;
                nxt_hold_s  = {HW{1'b0}};
            end
        endcase
    end

    // One-hot mux of the word belonging to the owner after this edge.
    always_comb begin
        data_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel_s = data_sel_s |
                         ({DATA_W{nxt_grant_s[i]}} & data_in[i*DATA_W +: DATA_W]);
        end
        nxt_data_s = (|nxt_grant_s) ? data_sel_s : BLANK_WORD;
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            last_idx_r <= LAST_RST;
            grant      <= {NUM_REQ{1'b0}};
            valid      <= 1'b0;
            switch     <= 1'b0;
            time_data  <= BLANK_WORD;
        end else begin
            state_r    <= nxt_state_s;
            hold_cnt_r <= nxt_hold_s;
            last_idx_r <= nxt_last_s;
            grant      <= nxt_grant_s;
            valid      <= |nxt_grant_s;
            switch     <= (nxt_grant_s != grant);
            time_data  <= nxt_data_s;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: each step drives inputs just after a
// rising edge and checks the registered outputs just after the next one.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_in;
    logic [2:0]  req;
    logic [95:0] data_in;
    logic [2:0]  grant;
    logic [31:0] time_data;
    logic        valid;
    logic        switch;

    int n_cmp = 0;
    int n_err = 0;

    display_arbiter #(
        .NUM_REQ(3), .DATA_W(32), .MIN_HOLD(4), .BLANK_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .req(req),
        .data_in(data_in), .grant(grant), .time_data(time_data),
        .valid(valid), .switch(switch)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick strobe lasting a single clock, followed by a quiet clock.
    task automatic tick2();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
    endtask

    initial begin
        rst     = 1'b1;
        tick_in = 1'b0;
        req     = 3'b000;
        data_in = {32'h0000_0777, 32'h0000_0159, 32'h0000_1234};
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
        check("rst_data", 64'(time_data), 64'hFFFF_FFFF);
        check("rst_switch", 64'(switch), 64'h0);

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_grant_switch", {60'h0, grant, switch}, 64'h0);
        end
        check("idle_data", 64'(time_data), 64'hFFFF_FFFF);

        // Single request from source 1
        req = 3'b010;
        cyc();
        check("g1_grant", 64'(grant), 64'h2);
        check("g1_data", 64'(time_data), 64'h0000_0159);
        check("g1_switch", 64'(switch), 64'h1);
        check("g1_valid", 64'(valid), 64'h1);
        cyc();
        check("g1_switch_off", 64'(switch), 64'h0);
        data_in[63:32] = 32'h0000_0200;
        cyc();
        check("g1_data_upd", 64'(time_data), 64'h0000_0200);

        // Competitors wait for MIN_HOLD ticks, then round-robin 1 -> 2 -> 0
        req = 3'b111;
        tick2(); tick2(); tick2();
        check("hold3_grant", 64'(grant), 64'h2);
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        check("hold4_grant", 64'(grant), 64'h2);
        check("hold4_switch", 64'(switch), 64'h0);
        cyc();
        check("rot2_grant", 64'(grant), 64'h4);
        check("rot2_switch", 64'(switch), 64'h1);
        check("rot2_data", 64'(time_data), 64'h0000_0777);
        tick2(); tick2(); tick2();
        check("rot2_hold_grant", 64'(grant), 64'h4);
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
        check("rot0_grant", 64'(grant), 64'h1);
        check("rot0_data", 64'(time_data), 64'h0000_1234);

        // Owner 0 drops on a tick with hold_cnt=2, only req[2] remains
        tick2(); tick2();
        req = 3'b100;
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        check("drop_to2_grant", 64'(grant), 64'h4);
        check("drop_to2_switch", 64'(switch), 64'h1);

        // Back to owner 0, then drop with req[1] and req[2] both pending
        req = 3'b001;
        cyc();
        check("back0_grant", 64'(grant), 64'h1);
        tick2(); tick2();
        req = 3'b110;
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        check("drop_to1_grant", 64'(grant), 64'h2);
        check("drop_to1_switch", 64'(switch), 64'h1);
        tick2(); tick2(); tick2();
        check("drop_hold_reset", 64'(grant), 64'h2);

        // Lone requester 0 keeps the display through 20 ticks
        req = 3'b001;
        cyc();
        check("solo_grant", 64'(grant), 64'h1);
        check("solo_switch", 64'(switch), 64'h1);
        for (int i = 0; i < 20; i++) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            check("solo_keep", {60'h0, grant, switch}, 64'h2);
        end

        // Single-cycle deassert still releases; competitor then held off
        req = 3'b100;
        cyc();
        req = 3'b101;
        check("glitch_grant", 64'(grant), 64'h4);
        cyc();
        check("glitch_hold", {60'h0, grant, switch}, 64'h8);

        // Reset while owner 2 holds and tick_in is high
        rst = 1'b1;
        tick_in = 1'b1;
        cyc();
        check("mrst_grant", 64'(grant), 64'h0);
        check("mrst_valid", 64'(valid), 64'h0);
        check("mrst_data", 64'(time_data), 64'hFFFF_FFFF);
        rst = 1'b0;
        tick_in = 1'b0;
        req = 3'b101;
        cyc();
        check("post_rst_grant", 64'(grant), 64'h1);
        check("post_rst_data", 64'(time_data), 64'h0000_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
